uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Transmit side of the UART: serialises one 7- or 8-bit character per load
//  into an 11-bit frame on tx.
//  - Frame: start bit, data LSB first, optional parity, stop bit(s).
//  - Pairs with the receive bit counter and uses the same eight/pen framing inputs.
//  - Sits between the CPU-facing transmit-data register and the serial pin.
//  - Has its own baud divider and bit counter.
// PARAMETERS
//  BAUD_W   19   width of baud_val and of the internal baud counter
// PORTS
//  clk       in   1       system clock; all state updates on posedge
//  reset     in   1       synchronous, active-low reset
//  load      in   1       one-cycle strobe: send data_in (accepted only when tx_rdy=1)
//  data_in   in   8       character to send; bit 7 ignored when eight=0
//  eight     in   1       1 = 8 data bits, 0 = 7 data bits
//  pen       in   1       parity enable
//  ohel      in   1       parity sense: 0 = even, 1 = odd
//  baud_val  in   BAUD_W  clocks per bit time
//  tx        out  1       serial output, idle high
//  tx_rdy    out  1       1 = idle, may load
//  tx_done   out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset (reset=0 at a clk edge):
//   - tx=1, tx_rdy=1, tx_done=0.
//   - Shift register = all 1s; baud counter = 0; bit counter = 0.
//   - Overrides everything, including mid-frame: the frame is aborted and
//     tx is high after that edge. No partial frame resumes.
//  Load:
//   - Accepted when load=1 and tx_rdy=1.
//   - On that edge: data_in, eight, pen, ohel and baud_val are latched into
//     an 11-bit frame register; tx_rdy goes to 0; baud and bit counters clear.
//   - Config changes later in the frame have no effect.
//   - load while tx_rdy=0 is ignored; no queuing, no error flag.
//  Frame bits (sent in order from bit 0; P = parity, 1 = stop):
//   - bit0 = 0 (start); bits1..7 = data[6:0]; bit10 = 1.
//   - {eight,pen}=00: bit8 = 1, bit9 = 1.
//   - {eight,pen}=01: bit8 = P over data[6:0], bit9 = 1.
//   - {eight,pen}=10: bit8 = data[7], bit9 = 1.
//   - {eight,pen}=11: bit8 = data[7], bit9 = P over data[7:0].
//   - P = XOR of the data bits, XOR ohel.
//  Timing:
//   - The start bit appears on tx the cycle after the load edge (latency 1).
//   - Each bit is held for exactly baud_val clocks; baud_val<2 is treated as 2.
//   - btu asserts when the baud counter reaches (baud_val-1). On btu the
//     counter clears, the frame shifts right with a 1 fill, and the bit
//     counter increments.
//  Completion:
//   - On the 11th btu: tx=1, tx_rdy=1, tx_done=1 for exactly one cycle.
//   - Total busy time = 11*baud_val clocks.
//   - load in the cycle tx_rdy returns high is accepted: back-to-back frames
//     with no extra idle bit.
//  Simultaneous events: reset beats load; the 11th btu beats a same-cycle load.
//  Width: the bit counter is 4 bits and saturates; it is never compared
//   past 11.
//  FSM: IDLE -(load)-> SHIFT -(bit count 11 on btu)-> IDLE; reset -> IDLE.
// TESTING
//  1. Reset with reset=0 during a frame:
//     -> tx=1, tx_rdy=1 at the next edge; no tx_done.
//  2. baud_val=4, eight=1, pen=0, data 0xA5:
//     -> tx = 0,1,0,1,0,0,1,0,1,1,1, each bit 4 clocks.
//     -> tx_done pulses at clock 44 after load; tx_rdy returns high there.
//  3. baud_val=4, eight=1, pen=1, ohel=0, data 0x55:
//     -> parity bit (bit9) = 0.
//     -> Repeat with ohel=1: bit9 = 1.
//  4. baud_val=4, eight=0, pen=1, ohel=1, data 0x83:
//     -> data bits 1,1,0,0,0,0,0; bit8 = P = 1; data[7] is never sent.
//  5. load pulsed mid-frame with a new value:
//     -> the current frame is unchanged and the second load is dropped.
//     -> load exactly on the tx_done cycle: the next start bit follows
//        immediately.
//  6. baud_val=0 and baud_val=1:
//     -> bit time = 2 clocks; the frame completes in 22 clocks.

Source files
------------

// File: rtl/uart_tx_engine.sv
// ----------------------------------------------------------------------------
// uart_tx_engine
//   Transmit half of the UART. Takes one 7- or 8-bit character per load and
//   sends it on tx as an 11-bit frame: start bit, data LSB first, an optional
//   parity bit, then stop bit(s) filling the frame out to 11 bits. The baud
//   divider and the bit counter belong to this block alone.
//
// Ports
//   clk       in   1       system clock, posedge
//   reset     in   1       synchronous reset, active low
//   load      in   1       strobe: send data_in (taken only while tx_rdy=1)
//   data_in   in   8       character; bit 7 unused when eight=0
//   eight     in   1       1 = 8 data bits, 0 = 7 data bits
//   pen       in   1       parity enable
//   ohel      in   1       parity sense, 0 = even, 1 = odd
//   baud_val  in   BAUD_W  clocks per bit (values below 2 act as 2)
//   tx        out  1       serial line, idle high
//   tx_rdy    out  1       idle, a load will be accepted
//   tx_done   out  1       one-cycle pulse when a frame completes
// ----------------------------------------------------------------------------
module uart_tx_engine #(
   parameter int BAUD_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [7:0]        data_in,
   input  logic              eight,
   input  logic              pen,
   input  logic              ohel,
   input  logic [BAUD_W-1:0] baud_val,
   output logic              tx,
   output logic              tx_rdy,
   output logic              tx_done
);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t            state_q;
   logic [10:0]       shift_q;
   logic [BAUD_W-1:0] baud_cnt_q;
   logic [BAUD_W-1:0] baud_lim_q;   // latched bit time minus one
   logic [3:0]        bit_cnt_q;
   logic              rdy_q;
   logic              done_q;

   logic              par7_d;
   logic              par8_d;
   logic              bit8_d;
   logic              bit9_d;
   logic [10:0]       frame_d;
   logic [BAUD_W-1:0] baud_lim_d;
   logic              btu_d;

   // Frame assembled from the live inputs; only used on the load edge.
   always_comb begin
      par7_d     = (^data_in[6:0]) ^ ohel;
      par8_d     = (^data_in) ^ ohel;
      bit8_d     = eight ? data_in[7] : (pen ? par7_d : 1'b1);
      bit9_d     = (eight && pen) ? par8_d : 1'b1;
      frame_d    = {1'b1, bit9_d, bit8_d, data_in[6:0], 1'b0};
      // Clamp bit time to a minimum of 2 clocks.
      baud_lim_d = (baud_val < BAUD_W'(2)) ? BAUD_W'(1) : (baud_val - BAUD_W'(1));
      btu_d      = (baud_cnt_q == baud_lim_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         shift_q    <= '1;
         baud_cnt_q <= '0;
         baud_lim_q <= '0;
         bit_cnt_q  <= '0;
         rdy_q      <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  shift_q    <= frame_d;
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  baud_lim_q <= baud_lim_d;
                  rdy_q      <= 1'b0;
                  state_q    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (btu_d) begin
                  baud_cnt_q <= '0;
                  // Ones shift in, so the line is high once the frame is out.
                  shift_q    <= {1'b1, shift_q[10:1]};
                  if (bit_cnt_q != 4'hF) bit_cnt_q <= bit_cnt_q + 4'd1;
                  // Eleventh bit time ends here; load this cycle is ignored.
                  if (bit_cnt_q == 4'd10) begin
                     rdy_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx      = shift_q[0];
   assign tx_rdy  = rdy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_engine
//   Drives directed and random frames into uart_tx_engine and compares the
//   serial line, tx_rdy and tx_done every clock against a reference that
//   builds each frame as a list of bits from the framing rules.
// ----------------------------------------------------------------------------
module tb_uart_tx_engine;

   localparam int BAUD_W = 19;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              load = 1'b0;
   logic [7:0]        data_in = '0;
   logic              eight = 1'b0;
   logic              pen = 1'b0;
   logic              ohel = 1'b0;
   logic [BAUD_W-1:0] baud_val = '0;
   logic              tx;
   logic              tx_rdy;
   logic              tx_done;

   int n_chk  = 0;
   int n_fail = 0;

   uart_tx_engine #(.BAUD_W(BAUD_W)) dut (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in),
      .eight(eight), .pen(pen), .ohel(ohel), .baud_val(baud_val),
      .tx(tx), .tx_rdy(tx_rdy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference frame: start, the data bits, parity if enabled, stops to 11.
   function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                               input logic p, input logic o);
      logic [10:0] f;
      int n;
      int ones;
      f    = '1;
      n    = e ? 8 : 7;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < n; i++) begin
         f[1+i] = d[i];
         ones  += int'(d[i]);
      end
      if (p) f[1+n] = ((ones % 2) == 1) ^ o;
      return f;
   endfunction

   // Called at a negedge. Loads one frame, then checks every cycle until the
   // done cycle, returning at the negedge inside the done cycle. mc >= 0 pulses
   // a stray load (with scrambled config) mc cycles into the frame.
   task automatic run_frame(input logic [7:0] d, input logic e, input logic p,
                            input logic o, input int bv, input int mc);
      logic [10:0] bits;
      int          eff;
      chk("rdy_before_load", tx_rdy, 1);
      data_in  = d; eight = e; pen = p; ohel = o;
      baud_val = BAUD_W'(bv);
      load     = 1'b1;
      bits     = model_frame(d, e, p, o);
      eff      = (bv < 2) ? 2 : bv;
      @(negedge clk);
      for (int c = 0; c < 11 * eff; c++) begin
         load = 1'b0;
         chk("tx_bit", tx, bits[c / eff]);
         chk("rdy_busy", tx_rdy, 0);
         chk("done_busy", tx_done, 0);
         if (c == mc) begin
            load     = 1'b1;
            data_in  = ~d;
            eight    = 1'($urandom);
            pen      = 1'($urandom);
            ohel     = 1'($urandom);
            baud_val = BAUD_W'($urandom_range(0, 9));
         end
         @(negedge clk);
      end
      load = 1'b0;
      chk("done_pulse", tx_done, 1);
      chk("rdy_done", tx_rdy, 1);
      chk("tx_done_high", tx, 1);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_rdy", tx_rdy, 1);
      chk("idle_done", tx_done, 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_rdy", tx_rdy, 1);
      chk("rst_done", tx_done, 0);
      reset = 1'b1;
      idle_cycle();

      // 8N, 0xA5, with a stray load mid-frame
      run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 4, 17);
      idle_cycle();
      // 8 data + even / odd parity
      run_frame(8'h55, 1'b1, 1'b1, 1'b0, 4, -1);
      idle_cycle();
      run_frame(8'h55, 1'b1, 1'b1, 1'b1, 4, -1);
      // back-to-back: loaded in the done cycle, 7 data + odd parity
      run_frame(8'h83, 1'b0, 1'b1, 1'b1, 4, -1);
      idle_cycle();
      // bit time clamps; stray load on the final btu edge must be dropped
      run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, 21);
      idle_cycle();
      run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1, -1);
      idle_cycle();

      // Random frames, random gaps, occasional stray loads
      for (int k = 0; k < 25; k++) begin
         int bv;
         int eff;
         int mc;
         bv  = $urandom_range(0, 6);
         eff = (bv < 2) ? 2 : bv;
         mc  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 11 * eff - 1) : -1;
         run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), bv, mc);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      // Reset mid-frame aborts it
      idle_cycle();
      data_in = 8'h00; eight = 1'b1; pen = 1'b0; baud_val = BAUD_W'(4);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (6) @(negedge clk);
      chk("midframe_busy", tx_rdy, 0);
      chk("midframe_tx", tx, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_tx", tx, 1);
      chk("abort_rdy", tx_rdy, 1);
      chk("abort_done", tx_done, 0);
      reset = 1'b1;
      for (int c = 0; c < 50; c++) idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
